mv_pattern_multi: RTL and testbench
===================================

Name: mv_pattern_multi

Overview:
- Parametrised successor to the single-mode border test pattern in the HDMI-out pattern set.
- Selects one of four patterns at run time: border, border+grid, bouncing box, or blinking border.
- Per-frame state (mode latch, frame counter, box position and direction) is updated at frame start.
- Sits between the video timing generator and the pattern mux/encoder. Output timing is delayed by exactly 1 clk.

Parameters:
- DW, 8, colour channel width.
- BORDER_W, 1, border thickness in pixels (≥1).
- GRID_LOG2, 6, grid pitch = 2^GRID_LOG2 pixels (1..11).
- BOX_SIZE, 32, box edge in pixels.
- BOX_STEP, 2, box move per frame in pixels (≥1).
- FRAME_DIV, 30, frames per blink half-period (≥1).
- VS_POL, 1, active level of timing_vs.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  synchronous reset, active-low.
- hactive  in  16  active width.
- vactive  in  16  active height.
- mode  in  2  0=border, 1=grid, 2=box, 3=blink.
- timing_hs  in  1  hsync.
- timing_vs  in  1  vsync.
- timing_de  in  1  data enable.
- timing_x  in  12  pixel x.
- timing_y  in  12  pixel y.
- hs, vs, de  out  1  timing inputs delayed 1 clk.
- rgb_r, rgb_g, rgb_b  out  DW  pixel colour.

Behaviour:
- **Reset** (rst_n=0 at posedge clk): hs, vs, de, rgb_* = 0. mode_q=0, frame_cnt=0, blink_ph=0, box_x=box_y=0, dir_x=dir_y=+ (increasing). Reset mid-frame takes effect on the next edge; the first frame start after release behaves normally.
- **Latency**: all outputs are registered, 1 clk from timing_* to outputs. When timing_de=0, the next rgb is 0.
- **Frame start (fs)**: the cycle where vs_d0 != VS_POL and timing_vs == VS_POL. vs_d0 is the registered output vs. There is no fs in the first cycle after reset.
- **At fs**:
  - mode_q <= mode.
  - frame_cnt increments. At FRAME_DIV-1 it wraps to 0 and toggles blink_ph.
  - Box moves per the box rules below.
  - Mode is never applied mid-frame.
- **Coordinates**: x/y are zero-extended to 16 bits.
- **border** = x<BORDER_W or y<BORDER_W or x+BORDER_W>=hactive or y+BORDER_W>=vactive. Compute x+BORDER_W in 17 bits so it cannot wrap. If hactive=0 or vactive=0, the right/bottom terms are false.
- **grid** = low GRID_LOG2 bits of x all zero, or low GRID_LOG2 bits of y all zero.
- **inbox** = box_x<=x<box_x+BOX_SIZE and box_y<=y<box_y+BOX_SIZE (17-bit sums).
- **Colour per mode_q** (DE active):
  - mode 0: white if border, else black.
  - mode 1: white if border; else green if grid; else black.
  - mode 2: white if border; else red if inbox; else black.
  - mode 3: white on border when blink_ph=0, blue on border when blink_ph=1; black elsewhere.
- **Box x-axis motion** (y identical with vactive/dir_y):
  - Let lim = hactive-BOX_SIZE.
  - If hactive<=BOX_SIZE: box_x=0, dir_x=+.
  - Else if dir_x=+: if box_x+BOX_STEP>=lim, then box_x=lim and dir_x=-; else box_x+=BOX_STEP.
  - Else (dir_x=-): if box_x<=BOX_STEP, then box_x=0 and dir_x=+; else box_x-=BOX_STEP.
  - If hactive shrinks so box_x>lim, the next fs clamps box_x to lim and sets dir_x=-.
- The box registers advance in every mode, so switching to mode 2 never restarts the motion.

Decomposition:
- Package mv_pattern_pkg:
  - Mode encoding constants MODE_BORDER/GRID/BOX/BLINK.
  - Colour constants for white, black, red, green and blue, each scaled to DW (all-ones / zero).
- Sub-module mv_box_axis: one axis of the box motion; instantiated twice.
  - Ports: clk, rst_n, step_en(=fs), extent[15:0], pos[15:0], dir.
  - Parameters: SIZE, STEP.

Test Plan:
- Reset, then 8x6 frame, mode=0, BORDER_W=1 → de/hs/vs delayed 1 clk; rgb=FF at x∈{0,7} or y∈{0,5}; interior 00; blanking 00.
- mode=1, GRID_LOG2=2, 16x12 frame → interior pixels with x∈{4,8,12} or y∈{4,8} are green (00,FF,00); other interior pixels black.
- mode changed from 0 to 2 at x=3,y=2 → rest of frame stays mode 0; next frame shows mode 2.
- hactive=vactive=64, BOX_SIZE=32, BOX_STEP=2, mode=2 → box_x sequence over frames 0,2,…,30,32,30; dir flips at 32; red square tracks box_x/box_y.
- mode=3, FRAME_DIV=3 → border white for frames 1-2, blue for frames 3-5, white from frame 6; frame_cnt wraps 2→0.
- rst_n low for 1 clk mid-frame while box at x=20 → next clk all outputs 0 and box_x=0; hactive=16<BOX_SIZE → box_x stays 0.

Source files
------------

// File: rtl/mv_pattern_pkg.sv
// Shared mode encodings and colour selectors for the multi-mode test pattern.
// Colours are {r,g,b} on/off selectors; the top widens each bit to a full channel.
package mv_pattern_pkg;

  localparam logic [1:0] MODE_BORDER = 2'd0;
  localparam logic [1:0] MODE_GRID   = 2'd1;
  localparam logic [1:0] MODE_BOX    = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  typedef logic [2:0] rgb_sel_t;

  localparam rgb_sel_t COL_WHITE = 3'b111;
  localparam rgb_sel_t COL_BLACK = 3'b000;
  localparam rgb_sel_t COL_RED   = 3'b100;
  localparam rgb_sel_t COL_GREEN = 3'b010;
  localparam rgb_sel_t COL_BLUE  = 3'b001;

endpackage

// File: rtl/mv_box_axis.sv
// One axis of the bouncing box: moves STEP per frame between 0 and extent-SIZE.
// Updates only on step_en (frame start); no backpressure. dir=0 means increasing.
module mv_box_axis #(
  parameter int SIZE = 32,
  parameter int STEP = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step_en,
  input  logic [15:0] extent,
  output logic [15:0] pos,
  output logic        dir
);

  logic [16:0] lim;
  logic [16:0] pos17;

  assign pos17 = {1'b0, pos};
  assign lim   = {1'b0, extent} - 17'(SIZE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos <= '0;
      dir <= 1'b0;
    end else if (step_en) begin
      if ({1'b0, extent} <= 17'(SIZE)) begin
        pos <= '0;
        dir <= 1'b0;
      end else if (pos17 > lim) begin
        // extent shrank under the box: pull it back to the new edge
        pos <= lim[15:0];
        dir <= 1'b1;
      end else if (!dir) begin
        if (pos17 + 17'(STEP) >= lim) begin
          pos <= lim[15:0];
          dir <= 1'b1;
        end else begin
          pos <= pos + 16'(STEP);
        end
      end else if (pos17 <= 17'(STEP)) begin
        pos <= '0;
        dir <= 1'b0;
      end else begin
        pos <= pos - 16'(STEP);
      end
    end
  end

endmodule

// File: rtl/mv_pattern_multi.sv
// Run-time selectable test pattern (border, grid, bouncing box, blinking border).
// All outputs registered, 1 clk after timing_*; pure streaming, no backpressure.
module mv_pattern_multi
  import mv_pattern_pkg::*;
#(
  parameter int DW        = 8,
  parameter int BORDER_W  = 1,
  parameter int GRID_LOG2 = 6,
  parameter int BOX_SIZE  = 32,
  parameter int BOX_STEP  = 2,
  parameter int FRAME_DIV = 30,
  parameter bit VS_POL    = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   hactive,
  input  logic [15:0]   vactive,
  input  logic [1:0]    mode,
  input  logic          timing_hs,
  input  logic          timing_vs,
  input  logic          timing_de,
  input  logic [11:0]   timing_x,
  input  logic [11:0]   timing_y,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [DW-1:0] rgb_r,
  output logic [DW-1:0] rgb_g,
  output logic [DW-1:0] rgb_b
);

  logic        fs_arm;
  logic        fs;
  logic [1:0]  mode_q;
  logic [15:0] frame_cnt;
  logic        blink_ph;
  logic [15:0] box_x;
  logic [15:0] box_y;
  logic        dir_x;
  logic        dir_y;
  logic [16:0] x17;
  logic [16:0] y17;
  logic        border;
  logic        grid;
  logic        inbox;
  rgb_sel_t    col;

  // fs_arm masks the cycle right after reset, when vs is forced low rather than sampled
  assign fs = fs_arm && (vs != VS_POL) && (timing_vs == VS_POL);

  assign x17 = {5'd0, timing_x};
  assign y17 = {5'd0, timing_y};

  assign border = (x17 < 17'(BORDER_W)) || (y17 < 17'(BORDER_W)) ||
                  ((hactive != 16'd0) && (x17 + 17'(BORDER_W) >= {1'b0, hactive})) ||
                  ((vactive != 16'd0) && (y17 + 17'(BORDER_W) >= {1'b0, vactive}));

  assign grid = (timing_x[GRID_LOG2-1:0] == '0) || (timing_y[GRID_LOG2-1:0] == '0);

  assign inbox = (x17 >= {1'b0, box_x}) && (x17 < {1'b0, box_x} + 17'(BOX_SIZE)) &&
                 (y17 >= {1'b0, box_y}) && (y17 < {1'b0, box_y} + 17'(BOX_SIZE));

  always_comb begin
    col = COL_BLACK;
    if (timing_de) begin
      case (mode_q)
        MODE_BORDER: col = border ? COL_WHITE : COL_BLACK;
        MODE_GRID:   col = border ? COL_WHITE : (grid ? COL_GREEN : COL_BLACK);
        MODE_BOX:    col = border ? COL_WHITE : (inbox ? COL_RED : COL_BLACK);
        default:     col = border ? (blink_ph ? COL_BLUE : COL_WHITE) : COL_BLACK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs        <= 1'b0;
      vs        <= 1'b0;
      de        <= 1'b0;
      rgb_r     <= '0;
      rgb_g     <= '0;
      rgb_b     <= '0;
      fs_arm    <= 1'b0;
      mode_q    <= MODE_BORDER;
      frame_cnt <= '0;
      blink_ph  <= 1'b0;
    end else begin
      hs     <= timing_hs;
      vs     <= timing_vs;
      de     <= timing_de;
      rgb_r  <= {DW{col[2]}};
      rgb_g  <= {DW{col[1]}};
      rgb_b  <= {DW{col[0]}};
      fs_arm <= 1'b1;
      if (fs) begin
        mode_q <= mode;
        if (frame_cnt == 16'(FRAME_DIV - 1)) begin
          frame_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          frame_cnt <= frame_cnt + 16'd1;
        end
      end
    end
  end

  mv_box_axis #(.SIZE(BOX_SIZE), .STEP(BOX_STEP)) u_axis_x (
    .clk(clk), .rst_n(rst_n), .step_en(fs), .extent(hactive), .pos(box_x), .dir(dir_x)
  );

  mv_box_axis #(.SIZE(BOX_SIZE), .STEP(BOX_STEP)) u_axis_y (
    .clk(clk), .rst_n(rst_n), .step_en(fs), .extent(vactive), .pos(box_y), .dir(dir_y)
  );

endmodule

// File: tb/tb_mv_pattern_multi.sv
// Bench for mv_pattern_multi: scoreboard of expected outputs, one entry per driven cycle,
// compared when the registered output appears one clock later.
module tb_mv_pattern_multi;

  localparam int DW = 8;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] BLUE  = 24'h0000FF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   hactive, vactive;
  logic [1:0]    mode;
  logic          timing_hs, timing_vs, timing_de;
  logic [11:0]   timing_x, timing_y;
  logic          hs, vs, de;
  logic [DW-1:0] rgb_r, rgb_g, rgb_b;

  always #5 clk = ~clk;

  mv_pattern_multi #(
    .DW(DW), .BORDER_W(1), .GRID_LOG2(2), .BOX_SIZE(32), .BOX_STEP(2),
    .FRAME_DIV(3), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hactive(hactive), .vactive(vactive), .mode(mode),
    .timing_hs(timing_hs), .timing_vs(timing_vs), .timing_de(timing_de),
    .timing_x(timing_x), .timing_y(timing_y),
    .hs(hs), .vs(vs), .de(de), .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b)
  );

  typedef struct {
    logic        hs, vs, de;
    logic [23:0] rgb;
    string       name;
    int          x;
  } exp_t;

  typedef struct {
    int          md, ha, va;
    bit          pulse, h, d;
    int          x, y;
    logic [23:0] rgb;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[20];
  int   checks = 0;
  int   errors = 0;
  int   first_red;

  // reference state, updated at each modelled frame start
  int m_mode, m_cnt, m_bx, m_by;
  bit m_ph, m_dx, m_dy, m_prev_vs, m_armed;

  function automatic logic [23:0] model_rgb(input bit d, input int x, input int y);
    bit brd, grd, inb;
    if (!d) return BLACK;
    brd = (x < 1) || (y < 1) || (hactive != 0 && x + 1 >= int'(hactive)) ||
          (vactive != 0 && y + 1 >= int'(vactive));
    grd = (x % 4 == 0) || (y % 4 == 0);
    inb = (x >= m_bx) && (x < m_bx + 32) && (y >= m_by) && (y < m_by + 32);
    case (m_mode)
      0:       return brd ? WHITE : BLACK;
      1:       return brd ? WHITE : (grd ? GREEN : BLACK);
      2:       return brd ? WHITE : (inb ? RED : BLACK);
      default: return brd ? (m_ph ? BLUE : WHITE) : BLACK;
    endcase
  endfunction

  task automatic axis(input int ext, inout int pos, inout bit dn);
    int lim;
    lim = ext - 32;
    if (ext <= 32) begin pos = 0; dn = 0; end
    else if (pos > lim) begin pos = lim; dn = 1; end
    else if (!dn) begin
      if (pos + 2 >= lim) begin pos = lim; dn = 1; end
      else pos = pos + 2;
    end else if (pos <= 2) begin pos = 0; dn = 0; end
    else pos = pos - 2;
  endtask

  // One clock: check the output produced by the previous cycle, then drive this cycle.
  task automatic step(input bit rst, input bit h, input bit v, input bit d,
                      input int x, input int y, input string nm,
                      input bit use_exp, input logic [23:0] xrgb);
    exp_t        e;
    logic [26:0] act, want;
    @(negedge clk);
    if (sbq.size() > 0) begin
      e    = sbq.pop_front();
      act  = {hs, vs, de, rgb_r, rgb_g, rgb_b};
      want = {e.hs, e.vs, e.de, e.rgb};
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL %s x=%0d got=%h want=%h", e.name, e.x, act, want);
      end
      if (de === 1'b1 && {rgb_r, rgb_g, rgb_b} === RED && first_red < 0) first_red = e.x;
    end
    rst_n     = !rst;
    timing_hs = h;
    timing_vs = v;
    timing_de = d;
    timing_x  = x[11:0];
    timing_y  = y[11:0];
    e.name = nm;
    e.x    = x;
    if (rst) begin
      e.hs = 0; e.vs = 0; e.de = 0; e.rgb = BLACK;
      m_mode = 0; m_cnt = 0; m_ph = 0; m_bx = 0; m_by = 0; m_dx = 0; m_dy = 0;
      m_prev_vs = 0; m_armed = 0;
    end else begin
      e.hs = h; e.vs = v; e.de = d;
      e.rgb = use_exp ? xrgb : model_rgb(d, x, y);
      if (m_armed && !m_prev_vs && v) begin
        m_mode = int'(mode);
        if (m_cnt == 2) begin m_cnt = 0; m_ph = !m_ph; end
        else m_cnt = m_cnt + 1;
        axis(int'(hactive), m_bx, m_dx);
        axis(int'(vactive), m_by, m_dy);
      end
      m_prev_vs = v;
      m_armed   = 1;
    end
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 3, 0, "reset", 0, BLACK);
    step(0, 0, 0, 0, 0, 0, "idle", 0, BLACK);
  endtask

  task automatic vs_pulse();
    step(0, 0, 1, 0, 0, 0, "vsync", 0, BLACK);
    step(0, 0, 1, 0, 0, 0, "vsync", 0, BLACK);
    step(0, 1, 0, 0, 0, 0, "vblank", 0, BLACK);
  endtask

  task automatic scan_row(input int y, input int x0, input int x1);
    for (int x = x0; x < x1; x++) step(0, 0, 0, 1, x, y, "pix", 0, BLACK);
  endtask

  task automatic scan_frame(input int w, input int h);
    for (int y = 0; y < h; y++) begin
      scan_row(y, 0, w);
      step(0, 1, 0, 0, 0, y, "hblank", 0, BLACK);
    end
  endtask

  task automatic check_box(input string nm, input int want);
    checks++;
    if (first_red != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, first_red, want);
    end
  endtask

  initial begin
    tbl[0]  = '{0, 8, 6, 1, 0, 1, 0, 0, WHITE};
    tbl[1]  = '{0, 8, 6, 0, 0, 1, 7, 0, WHITE};
    tbl[2]  = '{0, 8, 6, 0, 0, 1, 3, 5, WHITE};
    tbl[3]  = '{0, 8, 6, 0, 0, 1, 0, 3, WHITE};
    tbl[4]  = '{0, 8, 6, 0, 0, 1, 7, 4, WHITE};
    tbl[5]  = '{0, 8, 6, 0, 0, 1, 3, 3, BLACK};
    tbl[6]  = '{0, 8, 6, 0, 0, 1, 6, 4, BLACK};
    tbl[7]  = '{0, 8, 6, 0, 0, 1, 1, 1, BLACK};
    tbl[8]  = '{0, 8, 6, 0, 1, 0, 0, 0, BLACK};
    tbl[9]  = '{1, 16, 12, 1, 0, 1, 4, 3, GREEN};
    tbl[10] = '{1, 16, 12, 0, 0, 1, 8, 1, GREEN};
    tbl[11] = '{1, 16, 12, 0, 0, 1, 12, 10, GREEN};
    tbl[12] = '{1, 16, 12, 0, 0, 1, 5, 4, GREEN};
    tbl[13] = '{1, 16, 12, 0, 0, 1, 3, 8, GREEN};
    tbl[14] = '{1, 16, 12, 0, 0, 1, 5, 5, BLACK};
    tbl[15] = '{1, 16, 12, 0, 0, 1, 13, 9, BLACK};
    tbl[16] = '{1, 16, 12, 0, 0, 1, 0, 4, WHITE};
    tbl[17] = '{1, 16, 12, 0, 0, 1, 15, 8, WHITE};
    tbl[18] = '{1, 16, 12, 0, 0, 1, 4, 11, WHITE};
    tbl[19] = '{1, 16, 12, 0, 1, 0, 4, 4, BLACK};

    hactive = 16'd8; vactive = 16'd6; mode = 2'd0;
    rst_n = 1'b0; timing_hs = 0; timing_vs = 0; timing_de = 0; timing_x = 0; timing_y = 0;
    first_red = -1;
    do_reset();

    // border frame 8x6 through the model
    vs_pulse();
    scan_frame(8, 6);

    // directed pixels
    for (int i = 0; i < 20; i++) begin
      mode    = tbl[i].md[1:0];
      hactive = tbl[i].ha[15:0];
      vactive = tbl[i].va[15:0];
      if (tbl[i].pulse) vs_pulse();
      step(0, tbl[i].h, 0, tbl[i].d, tbl[i].x, tbl[i].y, $sformatf("vec%0d", i), 1, tbl[i].rgb);
    end

    // mode switch mid-frame must wait for the next frame start
    hactive = 16'd8; vactive = 16'd6; mode = 2'd0;
    vs_pulse();
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 8; x++) begin
        if (y == 2 && x == 3) mode = 2'd2;
        step(0, 0, 0, 1, x, y, "mc_pix", 0, BLACK);
      end
      step(0, 1, 0, 0, 0, y, "hblank", 0, BLACK);
    end
    step(0, 0, 0, 1, 4, 3, "mc_old", 1, BLACK);
    vs_pulse();
    step(0, 0, 0, 1, 4, 3, "mc_new", 1, RED);
    scan_frame(8, 6);

    // bouncing box on 64x64, probe row 33
    hactive = 16'd64; vactive = 16'd64; mode = 2'd2;
    for (int k = 1; k <= 22; k++) begin
      vs_pulse();
      first_red = -1;
      scan_row(33, 0, 64);
      step(0, 1, 0, 0, 0, 33, "hblank", 0, BLACK);
      check_box($sformatf("box_x_f%0d", k), (k <= 16) ? 2 * k : 64 - 2 * k);
    end

    // one-cycle reset mid-line with the box at x=20
    scan_row(10, 0, 10);
    step(1, 0, 0, 1, 10, 10, "rst_mid", 1, BLACK);
    scan_row(10, 11, 64);
    step(0, 1, 0, 0, 0, 10, "hblank", 0, BLACK);
    vs_pulse();
    first_red = -1;
    scan_row(33, 0, 64);
    step(0, 1, 0, 0, 0, 33, "hblank", 0, BLACK);
    check_box("box_after_rst", 2);

    // active area smaller than the box pins it at 0
    hactive = 16'd16; vactive = 16'd16;
    vs_pulse();
    step(0, 0, 0, 1, 8, 8, "box_small", 1, RED);
    scan_frame(16, 16);
    vs_pulse();
    step(0, 0, 0, 1, 1, 1, "box_stay", 1, RED);

    // blink: FRAME_DIV=3 gives white 1-2, blue 3-5, white 6-7
    hactive = 16'd8; vactive = 16'd6; mode = 2'd3;
    do_reset();
    for (int f = 1; f <= 7; f++) begin
      vs_pulse();
      step(0, 0, 0, 1, 0, 0, $sformatf("blink_f%0d", f), 1, (f >= 3 && f <= 5) ? BLUE : WHITE);
      scan_frame(8, 6);
    end

    step(0, 0, 0, 0, 0, 0, "idle", 0, BLACK);
    step(0, 0, 0, 0, 0, 0, "idle", 0, BLACK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
